control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit bus CPU.
- Consumes the instruction register contents and ALU status, and drives every bus/register control strobe of the datapath: pc_*, mar_in, ram_*, ir_*, a_*, b_*, alu_out, output_in.
- Sequences fetch/execute as micro-steps T0..T4 and owns the carry/zero flag register.
- Datapath samples the control word on the next rising clk.

Parameters:
- OPCODE_W, 4, opcode width (ir[7:4]).
- STEP_W, 3, micro-step counter width; steps T0..T4 used.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- ir  in  8  instruction register; opcode = ir[7:4], operand = ir[3:0] (used by datapath).
- alu_carry  in  1  ALU carry/borrow out, valid in the same cycle as alu_out.
- alu_zero  in  1  ALU result == 0, valid in the same cycle as alu_out.
- pc_out, pc_add, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out, b_in, b_out, alu_out, alu_sub, output_in  out  1 each  control strobes.
- flag_c  out  1  registered carry flag.
- flag_z  out  1  registered zero flag.
- halted  out  1  CPU stopped.
- step  out  STEP_W  current micro-step (debug).

Behaviour:
- Reset (async, rst=1): step=0, flag_c=0, flag_z=0, halted=0. All strobes forced 0 while rst=1.
- Strobes are combinational from registered step, ir and flags only; no input-to-output paths from alu_*.
- At most one *_out strobe is active per step (bus single-driver rule).
- Fetch, all opcodes:
  - T0: pc_out, mar_in.
  - T1: ram_out, ir_in, pc_add.
- Execute, by opcode:
  - 0 NOP: T2 no strobes; end.
  - 1 LDA: T2 ir_out, mar_in. T3 ram_out, a_in; end.
  - 2 ADD: T2 ir_out, mar_in. T3 ram_out, b_in. T4 alu_out, a_in; latch flag_c<=alu_carry, flag_z<=alu_zero; end.
  - 3 SUB: as ADD, with alu_sub=1 in T4.
  - 4 STA: T2 ir_out, mar_in. T3 a_out, ram_in; end.
  - 5 LDI: T2 ir_out, a_in; end.
  - 6 JMP: T2 ir_out, pc_load; end.
  - 7 JC: T2 ir_out, plus pc_load only if flag_c=1; end.
  - 8 JZ: T2 ir_out, plus pc_load only if flag_z=1; end.
  - E OUT: T2 a_out, output_in; end.
  - F HLT: T2 no strobes; halted<=1 at end of T2.
  - 9–D (undefined): behave exactly as NOP.
- Step advance:
  - "end" means step<=0 on the next edge; otherwise step<=step+1.
  - step never exceeds 4. Any out-of-range step value also returns to 0.
- Halt:
  - Once halted=1, step holds at 0 and all strobes are 0.
  - flag_c and flag_z hold.
  - Only rst clears halted.
- Flags change only in T4 of ADD/SUB. Jumps use the flag value registered before the current instruction.
- rst asserted mid-instruction aborts immediately. The next instruction starts at T0 after release.
- Instruction cycle counts: NOP/LDI/JMP/JC/JZ/OUT = 3; LDA/STA = 4; ADD/SUB = 5.

Optional Feature:
- Macro: CPU_SINGLE_STEP_EN.
- Defined:
  - Adds input port step_req (1 bit).
  - The sequencer leaves T0 only in a cycle where step_req=1; otherwise it holds at T0 with all strobes 0.
  - Result: one instruction executes per step_req pulse.
  - A step_req held high runs continuously.
  - halted still dominates step_req.
- Undefined: no step_req port; T0 always advances.

Test Plan:
- Reset → step: assert rst mid-T3 of an LDA → all strobes 0 immediately. After release: step=0, T0 shows pc_out=mar_in=1 and no other strobes.
- LDA fetch/execute: ir=8'h1A → T2 ir_out+mar_in; T3 ram_out+a_in; step returns to 0 after 4 cycles. Each step has exactly one *_out strobe high.
- SUB with flags: ir=8'h3F, alu_carry=1, alu_zero=1 in T4 → alu_sub=alu_out=a_in=1; flag_c=flag_z=1 after the edge. A following JZ (ir=8'h85) asserts pc_load in T2.
- Conditional not taken: flag_c=0, ir=8'h73 → T2 ir_out=1, pc_load=0; 3-cycle instruction.
- HLT: ir=8'hF0 → halted=1 after T2. Over 20 further cycles step stays 0 and all strobes stay 0. Only rst clears halted.
- Undefined opcode plus single-step: ir=8'hB0 → 3-cycle NOP, no strobes in T2. With CPU_SINGLE_STEP_EN and step_req=0, step holds at 0; a 1-cycle step_req pulse runs exactly one instruction.

Source files
------------

// File: rtl/control_sequencer.sv
// Microcoded control sequencer for the 8-bit bus CPU: fetch/execute steps T0..T4, carry/zero flags, halt.
// Optional build macro CPU_SINGLE_STEP_EN adds a step_req input that gates leaving T0.
module control_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CPU_SINGLE_STEP_EN
    input  logic              step_req,
`endif
    input  logic [7:0]        ir,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              pc_out,
    output logic              pc_add,
    output logic              pc_load,
    output logic              mar_in,
    output logic              ram_in,
    output logic              ram_out,
    output logic              ir_in,
    output logic              ir_out,
    output logic              a_in,
    output logic              a_out,
    output logic              b_in,
    output logic              b_out,
    output logic              alu_out,
    output logic              alu_sub,
    output logic              output_in,
    output logic              flag_c,
    output logic              flag_z,
    output logic              halted,
    output logic [STEP_W-1:0] step
);
    localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
    localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
    localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h2);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h3);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h4);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h5);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h6);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'h7);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'h8);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

    logic [STEP_W-1:0]   r_step;
    logic                r_flag_c;
    logic                r_flag_z;
    logic                r_halted;

    logic [STEP_W-1:0]   w_step_nxt;
    logic [OPCODE_W-1:0] w_op;
    logic                w_go;
    logic                w_end;
    logic                w_set_halt;
    logic                w_latch_flags;
    logic                w_unused_operand;

    assign w_op             = ir[7 -: OPCODE_W];
    assign w_unused_operand = ^ir[7-OPCODE_W:0];

`ifdef CPU_SINGLE_STEP_EN
    assign w_go = step_req;
`else
    assign w_go = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step   <= T0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_step <= w_step_nxt;
            if (w_latch_flags) begin
                r_flag_c <= alu_carry;
                r_flag_z <= alu_zero;
            end
            if (w_set_halt)
                r_halted <= 1'b1;
        end
    end

    // Control word decode; rst and halt force every strobe low.
    always_comb begin
        pc_out = 1'b0;  pc_add  = 1'b0;  pc_load   = 1'b0;  mar_in = 1'b0;
        ram_in = 1'b0;  ram_out = 1'b0;  ir_in     = 1'b0;  ir_out = 1'b0;
        a_in   = 1'b0;  a_out   = 1'b0;  b_in      = 1'b0;  b_out  = 1'b0;
        alu_out = 1'b0; alu_sub = 1'b0;  output_in = 1'b0;
        w_end = 1'b0;  w_set_halt = 1'b0;  w_latch_flags = 1'b0;
        if (!rst && !r_halted) begin
            case (r_step)
                T0: if (w_go) begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                T1: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                    pc_add  = 1'b1;
                end
                T2: case (w_op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ir_out = 1'b1;
                        mar_in = 1'b1;
                    end
                    OP_LDI: begin ir_out = 1'b1; a_in = 1'b1;       w_end = 1'b1; end
                    OP_JMP: begin ir_out = 1'b1; pc_load = 1'b1;    w_end = 1'b1; end
                    OP_JC:  begin ir_out = 1'b1; pc_load = r_flag_c; w_end = 1'b1; end
                    OP_JZ:  begin ir_out = 1'b1; pc_load = r_flag_z; w_end = 1'b1; end
                    OP_OUT: begin a_out = 1'b1; output_in = 1'b1;   w_end = 1'b1; end
                    OP_HLT: begin w_set_halt = 1'b1;                 w_end = 1'b1; end
                    default: w_end = 1'b1;
                endcase
                T3: case (w_op)
                    OP_LDA: begin ram_out = 1'b1; a_in = 1'b1; w_end = 1'b1; end
                    OP_ADD, OP_SUB: begin ram_out = 1'b1; b_in = 1'b1; end
                    OP_STA: begin a_out = 1'b1; ram_in = 1'b1; w_end = 1'b1; end
                    default: w_end = 1'b1;
                endcase
                T4: begin
                    w_end = 1'b1;
                    if (w_op == OP_ADD || w_op == OP_SUB) begin
                        alu_out       = 1'b1;
                        a_in          = 1'b1;
                        alu_sub       = (w_op == OP_SUB);
                        w_latch_flags = 1'b1;
                    end
                end
                default: w_end = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_step_nxt = r_step + STEP_W'(1);
        if (r_halted || w_end)
            w_step_nxt = T0;
        else if (r_step == T0 && !w_go)
            w_step_nxt = T0;
    end

    assign flag_c = r_flag_c;
    assign flag_z = r_flag_z;
    assign halted = r_halted;
    assign step   = r_step;
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: instruction vector table plus reset, halt and single-step sequences.
module tb_control_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ir = 8'h00;
    logic       alu_carry = 1'b0;
    logic       alu_zero = 1'b0;
`ifdef CPU_SINGLE_STEP_EN
    logic       step_req = 1'b1;
`endif
    logic pc_out, pc_add, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out;
    logic a_in, a_out, b_in, b_out, alu_out, alu_sub, output_in;
    logic flag_c, flag_z, halted;
    logic [2:0] step;

    control_sequencer #(.OPCODE_W(4), .STEP_W(3)) dut (
        .clk(clk), .rst(rst),
`ifdef CPU_SINGLE_STEP_EN
        .step_req(step_req),
`endif
        .ir(ir), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .pc_out(pc_out), .pc_add(pc_add), .pc_load(pc_load), .mar_in(mar_in),
        .ram_in(ram_in), .ram_out(ram_out), .ir_in(ir_in), .ir_out(ir_out),
        .a_in(a_in), .a_out(a_out), .b_in(b_in), .b_out(b_out),
        .alu_out(alu_out), .alu_sub(alu_sub), .output_in(output_in),
        .flag_c(flag_c), .flag_z(flag_z), .halted(halted), .step(step)
    );

    always #5 clk = ~clk;

    localparam logic [14:0] PO = 15'h4000, PA = 15'h2000, PL = 15'h1000, MI = 15'h0800;
    localparam logic [14:0] RI = 15'h0400, RO = 15'h0200, II = 15'h0100, IO = 15'h0080;
    localparam logic [14:0] AI = 15'h0040, AO = 15'h0020, BI = 15'h0010, BO = 15'h0008;
    localparam logic [14:0] EO = 15'h0004, SU = 15'h0002, OI = 15'h0001;
    localparam logic [14:0] F0 = PO | MI;
    localparam logic [14:0] F1 = RO | II | PA;

    logic [14:0] act;
    assign act = {pc_out, pc_add, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out,
                  a_in, a_out, b_in, b_out, alu_out, alu_sub, output_in};

    typedef struct packed {
        logic [7:0]       ir;
        logic             c;
        logic             z;
        logic [2:0]       n;
        logic [4:0][14:0] exp;
        logic             fc;
        logic             fz;
    } vec_t;

    typedef struct {
        logic [2:0]  st;
        logic [14:0] sb;
    } sb_t;

    sb_t  q[$];
    vec_t tbl[17];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic vec_t mk(input logic [7:0] i, input logic c, input logic z,
                                input logic [2:0] n, input logic [14:0] e2,
                                input logic [14:0] e3, input logic [14:0] e4,
                                input logic fc, input logic fz);
        vec_t v;
        v.ir = i; v.c = c; v.z = z; v.n = n;
        v.exp[0] = F0; v.exp[1] = F1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
        v.fc = fc; v.fz = fz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, a, e);
    endtask

    task automatic compare_pop(input string tag);
        sb_t x;
        if (q.size() == 0) begin
            n_chk++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            x = q.pop_front();
            chk({tag, " step"}, 32'(step), 32'(x.st));
            chk({tag, " strobes"}, 32'(act), 32'(x.sb));
        end
    endtask

    // Entered at posedge+1 with inputs already driven; leaves at the next posedge+1.
    task automatic cycle(input logic [2:0] st, input logic [14:0] sb, input string tag);
        sb_t x;
        x.st = st; x.sb = sb;
        q.push_back(x);
        @(negedge clk);
        compare_pop(tag);
        @(posedge clk);
        #1;
    endtask

    // ALU status is inverted outside T4 so any latch outside T4 corrupts the flags.
    task automatic run_vec(input vec_t v, input int idx);
        for (int t = 0; t < int'(v.n); t++) begin
            ir        = v.ir;
            alu_carry = (t == 4) ? v.c : ~v.c;
            alu_zero  = (t == 4) ? v.z : ~v.z;
            cycle(3'(t), v.exp[t], $sformatf("v%0d ir=%02h T%0d", idx, v.ir, t));
        end
        chk($sformatf("v%0d flag_c", idx), 32'(flag_c), 32'(v.fc));
        chk($sformatf("v%0d flag_z", idx), 32'(flag_z), 32'(v.fz));
    endtask

    initial begin
        tbl[0]  = mk(8'h1A, 0, 0, 4, IO | MI, RO | AI, 0, 0, 0);
        tbl[1]  = mk(8'h3F, 1, 1, 5, IO | MI, RO | BI, EO | AI | SU, 1, 1);
        tbl[2]  = mk(8'h85, 0, 0, 3, IO | PL, 0, 0, 1, 1);
        tbl[3]  = mk(8'h21, 0, 0, 5, IO | MI, RO | BI, EO | AI, 0, 0);
        tbl[4]  = mk(8'h73, 1, 1, 3, IO, 0, 0, 0, 0);
        tbl[5]  = mk(8'h80, 1, 1, 3, IO, 0, 0, 0, 0);
        tbl[6]  = mk(8'h4C, 1, 1, 4, IO | MI, AO | RI, 0, 0, 0);
        tbl[7]  = mk(8'h55, 1, 1, 3, IO | AI, 0, 0, 0, 0);
        tbl[8]  = mk(8'h6A, 1, 1, 3, IO | PL, 0, 0, 0, 0);
        tbl[9]  = mk(8'hE0, 1, 1, 3, AO | OI, 0, 0, 0, 0);
        tbl[10] = mk(8'h00, 1, 1, 3, 0, 0, 0, 0, 0);
        tbl[11] = mk(8'hB0, 1, 1, 3, 0, 0, 0, 0, 0);
        tbl[12] = mk(8'h27, 1, 0, 5, IO | MI, RO | BI, EO | AI, 1, 0);
        tbl[13] = mk(8'h71, 0, 0, 3, IO | PL, 0, 0, 1, 0);
        tbl[14] = mk(8'h82, 0, 0, 3, IO, 0, 0, 1, 0);
        tbl[15] = mk(8'hD0, 0, 0, 3, 0, 0, 0, 1, 0);
        tbl[16] = mk(8'hF0, 0, 0, 3, 0, 0, 0, 1, 0);

        // Reset state: strobes gated low even though step is T0.
        repeat (2) @(posedge clk);
        #1;
        chk("rst step", 32'(step), 0);
        chk("rst strobes", 32'(act), 0);
        chk("rst flag_c", 32'(flag_c), 0);
        chk("rst flag_z", 32'(flag_z), 0);
        chk("rst halted", 32'(halted), 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

        // HLT, then 20 idle cycles with flags held.
        run_vec(tbl[16], 16);
        chk("halted set", 32'(halted), 1);
        for (int k = 0; k < 20; k++) begin
            ir = (k % 2 == 0) ? 8'h1A : 8'h3F;
            alu_carry = 1'b0; alu_zero = 1'b1;
            cycle(3'd0, 15'h0, $sformatf("halt c%0d", k));
        end
        chk("halt holds", 32'(halted), 1);
        chk("halt flag_c", 32'(flag_c), 1);
        chk("halt flag_z", 32'(flag_z), 0);
        rst = 1'b1;
        #1;
        chk("rst clears halted", 32'(halted), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Build up flags, then abort an LDA mid-T3 with reset.
        run_vec(tbl[12], 12);
        ir = 8'h1A;
        cycle(3'd0, F0, "abort T0");
        cycle(3'd1, F1, "abort T1");
        cycle(3'd2, IO | MI, "abort T2");
        begin
            sb_t x;
            x.st = 3'd3; x.sb = RO | AI;
            q.push_back(x);
            @(negedge clk);
            compare_pop("abort T3");
        end
        #1 rst = 1'b1;
        #1;
        chk("abort strobes", 32'(act), 0);
        chk("abort step", 32'(step), 0);
        chk("abort flag_c", 32'(flag_c), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(3'd0, F0, "restart T0");
        cycle(3'd1, F1, "restart T1");
        cycle(3'd2, IO | MI, "restart T2");
        cycle(3'd3, RO | AI, "restart T3");
        cycle(3'd0, F0, "restart next T0");
        cycle(3'd1, F1, "restart next T1");
        cycle(3'd2, IO | MI, "restart next T2");
        cycle(3'd3, RO | AI, "restart next T3");

`ifdef CPU_SINGLE_STEP_EN
        step_req = 1'b0;
        ir = 8'hB0;
        for (int k = 0; k < 4; k++) cycle(3'd0, 15'h0, $sformatf("ss idle%0d", k));
        step_req = 1'b1;
        cycle(3'd0, F0, "ss T0");
        step_req = 1'b0;
        cycle(3'd1, F1, "ss T1");
        cycle(3'd2, 15'h0, "ss T2");
        for (int k = 0; k < 3; k++) cycle(3'd0, 15'h0, $sformatf("ss after%0d", k));
`endif

        chk("scoreboard drained", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
